accel_spi_ctrl: RTL and testbench

- Sequencer sitting between the game logic and the 16-bit SPI serdes that talks to the on-board ADXL345-class accelerometer.
- After reset it waits out the sensor power-up time, verifies the device ID, then writes a fixed configuration.
- It then polls the X/Y data registers periodically and publishes signed tilt samples with a one-cycle valid strobe.
- All traffic goes through the serdes start/done handshake; this block is the serdes's only requester.

---
 rtl/accel_spi_pkg.sv | 49 ++++
 rtl/accel_spi_if.sv | 10 +
 rtl/accel_spi_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_accel_spi_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_spi_pkg.sv
// rtl/accel_spi_pkg.sv - register map, config ROM, state enums and frame helpers for accel_spi_ctrl
package accel_spi_pkg;

    localparam logic [5:0] DEVID       = 6'h00;
    localparam logic [5:0] BW_RATE     = 6'h2C;
    localparam logic [5:0] POWER_CTL   = 6'h2D;
    localparam logic [5:0] DATA_FORMAT = 6'h31;
    localparam logic [5:0] DATAX0      = 6'h32;
    localparam logic [5:0] DATAX1      = 6'h33;
    localparam logic [5:0] DATAY0      = 6'h34;
    localparam logic [5:0] DATAY1      = 6'h35;

    localparam logic [7:0] DEVID_VAL = 8'hE5;

    // Entry 0 is written first; each entry is {addr, data}.
    localparam int CFG_LEN = 3;
    localparam logic [CFG_LEN-1:0][13:0] CFG_ROM = {
        {POWER_CTL,   8'h08},
        {BW_RATE,     8'h0A},
        {DATA_FORMAT, 8'h08}
    };

    typedef enum logic [2:0] {
        M_PWRUP,
        M_IDREAD,
        M_IDCHK,
        M_IDWAIT,
        M_CFG,
        M_POLLWAIT,
        M_RD,
        M_PUBLISH
    } main_state_e;

    typedef enum logic [1:0] {
        T_IDLE,
        T_ISSUE,
        T_BUSY,
        T_GAP
    } txn_state_e;

    function automatic logic [15:0] mk_wr(input logic [5:0] addr, input logic [7:0] data);
        return {1'b0, 1'b0, addr, data};
    endfunction

    function automatic logic [15:0] mk_rd(input logic [5:0] addr);
        return {1'b1, 1'b0, addr, 8'h00};
    endfunction

endpackage

// File: rtl/accel_spi_if.sv
// rtl/accel_spi_if.sv - start/done handshake between the sequencer and the 16-bit SPI serdes
interface accel_spi_if;
    logic        sd_start;
    logic [15:0] sd_data_tx;
    logic        sd_done;
    logic [7:0]  sd_data_rx;

    modport master (output sd_start, output sd_data_tx, input sd_done, input sd_data_rx);
    modport slave  (input sd_start, input sd_data_tx, output sd_done, output sd_data_rx);
endinterface

// File: rtl/accel_spi_ctrl.sv
// rtl/accel_spi_ctrl.sv - accelerometer bring-up and X/Y polling sequencer in front of the SPI serdes
module accel_spi_ctrl
    import accel_spi_pkg::*;
#(
    parameter logic [15:0] PWRUP_CYCLES = 16'd2000,
    parameter logic [15:0] POLL_CYCLES  = 16'd20000,
    parameter logic [3:0]  CS_GAP       = 4'd2
) (
    input  logic               spi_clk,
    input  logic               reset_n,
    input  logic               enable,
    accel_spi_if.master        sd,
    output logic               init_done,
    output logic               id_err,
    output logic [15:0]        accel_x,
    output logic [15:0]        accel_y,
    output logic               sample_valid
);

    main_state_e       main_q;
    txn_state_e        txn_q;
    logic [1:0]        idx_q;
    logic [15:0]       cnt_q;
    logic [3:0]        gap_q;
    logic [15:0]       poll_q;
    logic              pend_q;
    logic [3:0][7:0]   b_q;
    logic              start_q;
    logic [15:0]       tx_q;
    logic              init_q;
    logic              id_err_q;
    logic [15:0]       ax_q;
    logic [15:0]       ay_q;
    logic              sv_q;

    logic              txn_end;
    logic              seq_more;
    logic [1:0]        last_idx;
    logic [1:0]        frame_idx;
    logic [15:0]       frame_d;

    // txn_end marks the last GAP cycle; the next ISSUE of a burst is launched on that edge.
    assign txn_end   = (txn_q == T_GAP) && (gap_q == CS_GAP - 4'd1);
    assign seq_more  = txn_end && (idx_q != last_idx);
    assign frame_idx = seq_more ? idx_q + 2'd1 : idx_q;

    always_comb begin
        last_idx = 2'd0;
        frame_d  = 16'h0000;
        case (main_q)
            M_IDREAD: frame_d = mk_rd(DEVID);
            M_CFG: begin
                last_idx = 2'(CFG_LEN - 1);
                frame_d  = mk_wr(CFG_ROM[frame_idx][13:8], CFG_ROM[frame_idx][7:0]);
            end
            M_RD: begin
                last_idx = 2'd3;
                frame_d  = mk_rd(DATAX0 + {4'b0000, frame_idx});
            end
            default: ;
        endcase
    end

    always_ff @(posedge spi_clk or negedge reset_n) begin
        if (!reset_n) begin
            main_q   <= M_PWRUP;
            txn_q    <= T_IDLE;
            idx_q    <= 2'd0;
            cnt_q    <= 16'd0;
            gap_q    <= 4'd0;
            poll_q   <= 16'd0;
            pend_q   <= 1'b0;
            b_q      <= '0;
            start_q  <= 1'b0;
            tx_q     <= 16'h0000;
            init_q   <= 1'b0;
            id_err_q <= 1'b0;
            ax_q     <= 16'h0000;
            ay_q     <= 16'h0000;
            sv_q     <= 1'b0;
        end else begin
            start_q <= 1'b0;
            sv_q    <= 1'b0;

            // Overruns collapse into the single pending flag.
            if (init_q) begin
                if (poll_q == POLL_CYCLES - 16'd1) begin
                    poll_q <= 16'd0;
                    pend_q <= 1'b1;
                end else begin
                    poll_q <= poll_q + 16'd1;
                end
            end

            case (txn_q)
                T_ISSUE: txn_q <= T_BUSY;
                T_BUSY: begin
                    if (sd.sd_done) begin
                        b_q[idx_q] <= sd.sd_data_rx;
                        gap_q      <= 4'd0;
                        txn_q      <= T_GAP;
                    end
                end
                T_GAP: begin
                    if (!txn_end) begin
                        gap_q <= gap_q + 4'd1;
                    end else if (seq_more) begin
                        idx_q   <= idx_q + 2'd1;
                        tx_q    <= frame_d;
                        start_q <= 1'b1;
                        txn_q   <= T_ISSUE;
                    end else begin
                        idx_q <= 2'd0;
                        txn_q <= T_IDLE;
                    end
                end
                default: begin
                    if (main_q == M_IDREAD || main_q == M_CFG || main_q == M_RD) begin
                        tx_q    <= frame_d;
                        start_q <= 1'b1;
                        txn_q   <= T_ISSUE;
                    end
                end
            endcase

            case (main_q)
                M_PWRUP: begin
                    if (cnt_q == PWRUP_CYCLES - 16'd1) begin
                        cnt_q  <= 16'd0;
                        main_q <= M_IDREAD;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                M_IDREAD: if (txn_end) main_q <= M_IDCHK;
                M_IDCHK: begin
                    if (b_q[0] == DEVID_VAL) begin
                        id_err_q <= 1'b0;
                        main_q   <= M_CFG;
                    end else begin
                        id_err_q <= 1'b1;
                        cnt_q    <= 16'd0;
                        main_q   <= M_IDWAIT;
                    end
                end
                M_IDWAIT: begin
                    if (cnt_q == POLL_CYCLES - 16'd1) begin
                        cnt_q  <= 16'd0;
                        main_q <= M_IDREAD;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                M_CFG: begin
                    // The first burst is due as soon as configuration lands.
                    if (txn_end && !seq_more) begin
                        init_q <= 1'b1;
                        pend_q <= 1'b1;
                        poll_q <= 16'd0;
                        main_q <= M_POLLWAIT;
                    end
                end
                M_POLLWAIT: begin
                    if (pend_q && enable) begin
                        pend_q <= 1'b0;
                        poll_q <= 16'd0;
                        main_q <= M_RD;
                    end
                end
                M_RD: begin
                    if (txn_end && !seq_more) begin
                        ax_q   <= {b_q[1], b_q[0]};
                        ay_q   <= {b_q[3], b_q[2]};
                        sv_q   <= 1'b1;
                        main_q <= M_PUBLISH;
                    end
                end
                M_PUBLISH: main_q <= M_POLLWAIT;
                default:   main_q <= M_PWRUP;
            endcase
        end
    end

    assign sd.sd_start   = start_q;
    assign sd.sd_data_tx = tx_q;
    assign init_done     = init_q;
    assign id_err        = id_err_q;
    assign accel_x       = ax_q;
    assign accel_y       = ay_q;
    assign sample_valid  = sv_q;

endmodule

// File: tb/tb_accel_spi_ctrl.sv
// tb/tb_accel_spi_ctrl.sv - directed bench for accel_spi_ctrl with a behavioural serdes and sensor
`timescale 1ns/1ps
module tb_accel_spi_ctrl;

    localparam int PWRUP_N = 40;
    localparam int POLL_N  = 300;
    localparam int GAP_N   = 2;

    logic        spi_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable  = 1'b0;
    logic        init_done;
    logic        id_err;
    logic [15:0] accel_x;
    logic [15:0] accel_y;
    logic        sample_valid;

    accel_spi_if sd ();

    accel_spi_ctrl #(
        .PWRUP_CYCLES (16'(PWRUP_N)),
        .POLL_CYCLES  (16'(POLL_N)),
        .CS_GAP       (4'(GAP_N))
    ) dut (
        .spi_clk      (spi_clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .sd           (sd),
        .init_done    (init_done),
        .id_err       (id_err),
        .accel_x      (accel_x),
        .accel_y      (accel_y),
        .sample_valid (sample_valid)
    );

    always #5 spi_clk = ~spi_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Serdes + sensor: done 18 cycles after start, DEVID answers 0x00 for the first id_bad_n reads.
    logic [4:0]  sd_cnt;
    logic        sd_busy;
    logic [15:0] sd_frame;
    int          devid_reads;
    int          id_bad_n = 0;
    logic [7:0]  regs [64];

    always @(posedge spi_clk or negedge reset_n) begin
        if (!reset_n) begin
            sd_busy       <= 1'b0;
            sd_cnt        <= 5'd0;
            sd_frame      <= 16'h0000;
            sd.sd_done    <= 1'b0;
            sd.sd_data_rx <= 8'h00;
            devid_reads   <= 0;
        end else begin
            sd.sd_done <= 1'b0;
            if (sd.sd_start) begin
                sd_busy  <= 1'b1;
                sd_cnt   <= 5'd1;
                sd_frame <= sd.sd_data_tx;
            end else if (sd_busy) begin
                sd_cnt <= sd_cnt + 5'd1;
                if (sd_cnt == 5'd17) begin
                    sd_busy    <= 1'b0;
                    sd.sd_done <= 1'b1;
                    if (sd_frame[15] && sd_frame[13:8] == 6'h00) begin
                        sd.sd_data_rx <= (devid_reads < id_bad_n) ? 8'h00 : 8'hE5;
                        devid_reads   <= devid_reads + 1;
                    end else if (sd_frame[15]) begin
                        sd.sd_data_rx <= regs[sd_frame[13:8]];
                    end else begin
                        sd.sd_data_rx <= 8'h00;
                    end
                end
            end
        end
    end

    int          cyc = 0;
    always @(posedge spi_clk) cyc <= cyc + 1;

    logic [15:0] frames [$];
    int          start_t [$];
    logic        id_at_start [$];
    int          since_done = 1000;
    logic        prev_start = 1'b0;
    logic        mon_busy = 1'b0;
    logic [15:0] mon_tx = 16'h0000;
    logic        tx_moved = 1'b0;
    int          sv_cnt = 0;
    int          start_cnt = 0;
    int          last_done = 0;
    int          init_rise = -1;

    always @(negedge spi_clk) begin
        if (!reset_n) begin
            mon_busy   = 1'b0;
            prev_start = 1'b0;
            since_done = 1000;
        end else begin
            if (sd.sd_start) begin
                chk("start_width", 32'(prev_start), 32'd0);
                chk("start_gap", 32'(since_done >= GAP_N), 32'd1);
                frames.push_back(sd.sd_data_tx);
                start_t.push_back(cyc);
                id_at_start.push_back(id_err);
                start_cnt++;
                mon_busy = 1'b1;
                mon_tx   = sd.sd_data_tx;
                tx_moved = 1'b0;
            end else if (mon_busy && sd.sd_data_tx != mon_tx) begin
                tx_moved = 1'b1;
            end
            if (sd.sd_done) begin
                chk("tx_stable", 32'(tx_moved), 32'd0);
                mon_busy   = 1'b0;
                since_done = 0;
                last_done  = cyc;
            end else begin
                since_done++;
            end
            if (sample_valid) sv_cnt++;
            if (init_done && init_rise < 0) init_rise = cyc;
            prev_start = sd.sd_start;
        end
    end

    logic [15:0] exp_init  [4] = '{16'h8000, 16'h3108, 16'h2C0A, 16'h2D08};
    logic [15:0] exp_rd    [4] = '{16'hB200, 16'hB300, 16'hB400, 16'hB500};
    logic [15:0] exp_retry [4] = '{16'h8000, 16'h8000, 16'h8000, 16'h3108};
    logic        exp_iderr [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        int t;
        int rel;
        int s1;
        int v1;
        int sv_base;

        for (int i = 0; i < 64; i++) regs[i] = 8'h00;
        regs[6'h32] = 8'h34;
        regs[6'h33] = 8'h12;
        regs[6'h34] = 8'hF0;
        regs[6'h35] = 8'hFF;
        enable  = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(negedge spi_clk);
        chk("rst_start", 32'(sd.sd_start), 32'd0);
        chk("rst_tx", 32'(sd.sd_data_tx), 32'd0);
        chk("rst_flags", 32'({init_done, id_err, sample_valid}), 32'd0);
        chk("rst_accel", {accel_x, accel_y}, 32'd0);

        // Clean bring-up then first poll burst.
        rel = cyc;
        reset_n = 1'b1;
        t = 0;
        while (!init_done && t < 2000) begin @(negedge spi_clk); t++; end
        chk("init_seen", 32'(init_done), 32'd1);
        @(negedge spi_clk);
        chk("init_frames_n", 32'(frames.size() >= 4), 32'd1);
        if (frames.size() >= 4) begin
            chk("pwrup_wait", 32'((start_t[0] - rel >= PWRUP_N) && (start_t[0] - rel <= PWRUP_N + 2)), 32'd1);
            for (int i = 0; i < 4; i++) chk("init_frame", 32'(frames[i]), 32'(exp_init[i]));
        end
        chk("init_lat", 32'(init_rise - last_done), 32'(GAP_N + 1));
        chk("id_ok", 32'(id_err), 32'd0);

        t = 0;
        while (!sample_valid && t < 500) begin @(negedge spi_clk); t++; end
        chk("sv_seen", 32'(sample_valid), 32'd1);
        chk("accel_x", 32'(accel_x), 32'h1234);
        chk("accel_y", 32'(accel_y), 32'hFFF0);
        chk("rd_frames_n", 32'(frames.size()), 32'd8);
        if (frames.size() >= 8)
            for (int i = 0; i < 4; i++) chk("rd_frame", 32'(frames[4 + i]), 32'(exp_rd[i]));
        @(negedge spi_clk);
        chk("sv_one_cycle", 32'(sample_valid), 32'd0);

        // enable low across two expiries, then exactly one burst.
        enable = 1'b0;
        s1 = start_cnt;
        repeat (2 * POLL_N + 40) @(negedge spi_clk);
        chk("no_burst_disabled", 32'(start_cnt - s1), 32'd0);
        enable = 1'b1;
        s1 = start_cnt;
        v1 = sv_cnt;
        t = 0;
        while (!sd.sd_start && t < 10) begin @(negedge spi_clk); t++; end
        chk("burst_after_rise", 32'(sd.sd_start), 32'd1);
        repeat (POLL_N - 40) @(negedge spi_clk);
        chk("one_burst_starts", 32'(start_cnt - s1), 32'd4);
        chk("one_burst_sv", 32'(sv_cnt - v1), 32'd1);

        // enable falling inside a burst does not stop it.
        t = 0;
        while (!(sd.sd_start && sd.sd_data_tx == 16'hB200) && t < 2 * POLL_N) begin @(negedge spi_clk); t++; end
        enable = 1'b0;
        t = 0;
        while (!sample_valid && t < 200) begin @(negedge spi_clk); t++; end
        chk("rd_enable_fall", 32'(sample_valid), 32'd1);
        enable = 1'b1;

        // Reset in the middle of the second read of a burst.
        t = 0;
        while (!(sd.sd_start && sd.sd_data_tx == 16'hB300) && t < 2 * POLL_N) begin @(negedge spi_clk); t++; end
        chk("rd2_seen", 32'(sd.sd_start), 32'd1);
        repeat (5) @(posedge spi_clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_flags", 32'({sd.sd_start, init_done, id_err, sample_valid}), 32'd0);
        chk("arst_tx", 32'(sd.sd_data_tx), 32'd0);
        chk("arst_accel", {accel_x, accel_y}, 32'd0);

        // Restart with two bad DEVID reads before the good one.
        id_bad_n = 2;
        frames.delete();
        start_t.delete();
        id_at_start.delete();
        sv_base = sv_cnt;
        init_rise = -1;
        repeat (3) @(negedge spi_clk);
        reset_n = 1'b1;
        t = 0;
        while (!init_done && t < PWRUP_N + 3 * POLL_N + 400) begin @(negedge spi_clk); t++; end
        chk("retry_init_seen", 32'(init_done), 32'd1);
        @(negedge spi_clk);
        chk("no_sv_after_abort", 32'(sv_cnt - sv_base), 32'd0);
        chk("retry_frames_n", 32'(frames.size() >= 4), 32'd1);
        if (frames.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("retry_frame", 32'(frames[i]), 32'(exp_retry[i]));
                chk("retry_id_err", 32'(id_at_start[i]), 32'(exp_iderr[i]));
            end
            chk("retry_space1", 32'(start_t[1] - start_t[0]), 32'(POLL_N + 23));
            chk("retry_space2", 32'(start_t[2] - start_t[1]), 32'(POLL_N + 23));
        end
        chk("retry_id_clear", 32'(id_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
